// File: rtl/uart_loader.sv
// uart_loader: serial program loader for the CPU memory-initialisation port.
//
// Receives UART bytes on rx (8N1, or 8E1 when UART_PARITY_EN is defined),
// packs them little-endian into 32-bit words and presents each word with
// its word index and a one-cycle write strobe. The transfer ends on an idle
// timeout (flushing any partial word zero-padded) or once word MAX_WORDS-1
// has been written. uart_finish then stays high until reset.
//
// Optional feature macro: UART_PARITY_EN (adds an even-parity bit check).
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active low
//   rx          in   asynchronous serial input, idle high
//   uart_data   out  assembled 32-bit word
//   uart_addr   out  word index of uart_data
//   uart_wen    out  one-cycle write strobe for uart_data/uart_addr
//   uart_finish out  transfer complete (sticky)
//   frame_err   out  bad stop bit or parity seen (sticky)
module uart_loader #(
  parameter int unsigned CLKS_PER_BIT   = 868,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_WORDS      = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [31:0] uart_data,
  output logic [31:0] uart_addr,
  output logic        uart_wen,
  output logic        uart_finish,
  output logic        frame_err
);

  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state;
  logic               rx_meta;
  logic               rx_sync;
  logic [CNT_W-1:0]   clk_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic [1:0]         byte_idx;
  logic [23:0]        word_buf;
  logic [TO_W-1:0]    to_cnt;
  logic               closing;
  logic               armed;
  logic               byte_ok;

`ifdef UART_PARITY_EN
  logic               par_bit;
  assign byte_ok = rx_sync && !(^{shift, par_bit});
`else
  assign byte_ok = rx_sync;
`endif

  // The timeout only runs once something has been received; uart_wen is
  // included so the cycle right after a completed word still counts.
  assign armed = uart_wen || (uart_addr != '0) || (byte_idx != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      byte_idx    <= '0;
      word_buf    <= '0;
      to_cnt      <= '0;
      closing     <= 1'b0;
      uart_data   <= '0;
      uart_addr   <= '0;
      uart_wen    <= 1'b0;
      uart_finish <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      uart_wen <= 1'b0;
      if (uart_wen) begin
        uart_addr <= uart_addr + 32'd1;
      end
      // closing marks that the strobe just issued was the final one.
      if (closing) begin
        uart_finish <= 1'b1;
      end

      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!(uart_finish || closing)) begin
            if (!rx_sync) begin
              state  <= START;
              to_cnt <= '0;
            end else if (armed) begin
              if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                to_cnt <= '0;
                if (byte_idx != '0) begin
                  // Unwritten lanes of word_buf are already zero.
                  uart_data <= {8'h00, word_buf};
                  uart_wen  <= 1'b1;
                  byte_idx  <= '0;
                  word_buf  <= '0;
                  closing   <= 1'b1;
                end else begin
                  uart_finish <= 1'b1;
                end
              end else begin
                to_cnt <= to_cnt + 1'b1;
              end
            end
          end
        end

        START: begin
          if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
            clk_cnt <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

`ifdef UART_PARITY_EN
        PARITY: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            par_bit <= rx_sync;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif

        STOP: begin
          if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
            clk_cnt <= '0;
            state   <= IDLE;
            to_cnt  <= '0;
            if (byte_ok) begin
              byte_idx <= byte_idx + 2'd1;
              case (byte_idx)
                2'd0: word_buf[7:0]   <= shift;
                2'd1: word_buf[15:8]  <= shift;
                2'd2: word_buf[23:16] <= shift;
                default: begin
                  uart_data <= {shift, word_buf};
                  uart_wen  <= 1'b1;
                  word_buf  <= '0;
                  if (uart_addr == 32'(MAX_WORDS - 1)) begin
                    closing <= 1'b1;
                  end
                end
              endcase
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Serial program loader that feeds the CPU core's memory-initialisation port. It receives 8N1 UART bytes from the host, assembles them little-endian into 32-bit words, and presents each word with its word address and a one-cycle write strobe. It asserts `uart_finish` when the transfer ends, which hands memory port B back to the pipeline. It sits between the board RX pin and the `uart_data` / `uart_addr` / `uart_finish` inputs of the CPU top.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); minimum 4.
- `TIMEOUT_CYCLES`, 1000000: idle-line cycles after the last byte that end the transfer.
- `MAX_WORDS`, 16384: word capacity; writing word `MAX_WORDS-1` ends the transfer.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, asynchronous, active-low.
- `rx` in 1: asynchronous serial input; idle high.
- `uart_data` out 32: assembled word.
- `uart_addr` out 32: word index of `uart_data`.
- `uart_wen` out 1: one-cycle write strobe; data and address are valid while it is high.
- `uart_finish` out 1: transfer complete; sticky until reset.
- `frame_err` out 1: sticky; set on a bad stop bit (or bad parity, see Configuration).

## Operation
- `rx` passes through a 2-flop synchroniser. Both flops reset to 1.
- RX FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE → START on a synchronised `rx` of 0.
  - START counts `CLKS_PER_BIT/2` cycles, then samples. If `rx` is 1 it returns to IDLE as a glitch; otherwise → DATA.
  - DATA takes 8 samples, each `CLKS_PER_BIT` cycles apart, LSB first.
  - STOP samples once, `CLKS_PER_BIT` after the last data bit. A 1 gives a valid byte; a 0 sets `frame_err` and discards the byte. Either way → IDLE.
- Assembler:
  - A 2-bit byte index selects the lane. Byte k goes to `[8k+7:8k]`.
  - On the 4th byte, `uart_data` takes the full word and `uart_wen` pulses.
- Addressing:
  - `uart_addr` starts at 0.
  - It increments in the cycle after each `uart_wen` pulse.
  - The address field wraps at 2^32, but `MAX_WORDS` ends the transfer first.
- Termination (only once `uart_addr` > 0 or the byte index ≠ 0):
  - Idle timeout: `TIMEOUT_CYCLES` consecutive cycles in IDLE with no new byte. If a partial word is pending (1–3 bytes), it is zero-padded and written with one `uart_wen` pulse, and `uart_finish` rises the next cycle. With no pending bytes, `uart_finish` rises immediately.
  - Capacity: `uart_finish` rises in the cycle after the `uart_wen` for word `MAX_WORDS-1`.
- After `uart_finish` the FSM stays in IDLE, ignores `rx`, and never pulses `uart_wen` again.
- A line that never carries a byte never times out, so `uart_finish` stays 0.

## Timing
- Reset values: `uart_data`=0, `uart_addr`=0, `uart_wen`=0, `uart_finish`=0, `frame_err`=0. FSM in IDLE, byte index 0, counters 0.
- Byte accepted on the cycle after the STOP sample. The 4th byte gives `uart_wen` =1 in that same cycle, so latency from STOP sample to strobe is 1 cycle.
- `uart_wen` is never high for two consecutive cycles.
- `uart_data` holds its value until the next word completes.
- The timeout counter clears on every accepted byte and on any START entry.
- A timeout expiring in the same cycle a byte is accepted: the byte wins and the counter clears.
- Reset asserted mid-frame: all state clears immediately. After release the block waits for a fresh falling edge.

## Configuration
- `UART_PARITY_EN` defined: the frame is 8E1 and the FSM includes PARITY, sampled `CLKS_PER_BIT` after bit 7. If the XOR of the 8 data bits and the parity bit is 1, the block sets `frame_err` and discards the byte even when the stop bit is good.
- `UART_PARITY_EN` undefined: the PARITY state and its logic are absent; the frame is 8N1.

## Test plan
All scenarios use `CLKS_PER_BIT`=4, `TIMEOUT_CYCLES`=64, `MAX_WORDS`=4.
- Bytes 0x13,0x05,0x00,0x00 → one `uart_wen` pulse with `uart_data`=0x00000513, `uart_addr`=0; `uart_addr`=1 the next cycle.
- Six bytes 0x11..0x16, then idle → word 0x14131211 @0, then after 64 idle cycles word 0x00001615 @1, `uart_finish`=1 one cycle later.
- 16 bytes → 4 pulses at addresses 0..3, `uart_finish`=1 the cycle after the 4th pulse; further bytes on `rx` produce no `uart_wen`.
- 2-cycle low glitch on `rx` → no byte, state back to IDLE. A frame with stop bit 0 → `frame_err`=1 and the byte index unchanged.
- `rst` pulled low during DATA of byte 2 → all outputs 0; next four clean bytes form the word at address 0.
- `UART_PARITY_EN`: byte 0x01 with parity bit 0 → `frame_err`=1, discarded; with parity bit 1 → accepted.
